// File: rtl/counter_run_arbiter_pkg.sv
// Shared definitions for the counter run arbiter: FSM state encoding,
// default range top and counting direction codes.
package counter_run_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int MAXVAL_DEFAULT = 30;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/counter_run_arbiter_core.sv
// Registered up/down counter datapath; a load takes priority over a step,
// and steps wrap modulo 2^WIDTH.
module updown_counter_core
  import counter_run_arbiter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  logic             mode,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step) begin
      q_d = (mode == DIR_DOWN) ? q_q - WIDTH'(1) : q_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_run_arbiter.sv
// Round-robin arbiter that hands the shared counter to one requester at a time,
// runs it from a range end to the latched target and pulses done to the owner.
module counter_run_arbiter
  import counter_run_arbiter_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int MAXVAL = MAXVAL_DEFAULT,
  parameter int NREQ   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       req_mode,
  input  logic [NREQ*WIDTH-1:0] req_target,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic                  cnt_mode
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAXVAL);

  state_e state_q, state_d;
  logic [IDXW-1:0] owner_q, owner_d, rrPtr_q, rrPtr_d;
  logic [IDXW-1:0] pickIdx, candIdx;
  logic pickFound;
  logic [WIDTH-1:0] target_q, target_d, pickTarget, loadVal, cntQ;
  logic cntMode_q, cntMode_d, load, step;
  logic [NREQ-1:0] done_q, done_d;

  // First active request at or after the round-robin pointer.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      candIdx = IDXW'((int'(rrPtr_q) + k) % NREQ);
      if (!pickFound && req[candIdx]) begin
        pickFound = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  assign pickTarget = req_target[int'(pickIdx)*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rrPtr_d   = rrPtr_q;
    target_d  = target_q;
    cntMode_d = cntMode_q;
    done_d    = '0;
    load      = 1'b0;
    loadVal   = '0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pickFound) begin
          owner_d   = pickIdx;
          target_d  = (pickTarget > MAXV) ? MAXV : pickTarget;
          cntMode_d = req_mode[pickIdx];
          load      = 1'b1;
          loadVal   = (req_mode[pickIdx] == DIR_DOWN) ? MAXV : '0;
          rrPtr_d   = (pickIdx == IDXW'(NREQ - 1)) ? '0 : pickIdx + IDXW'(1);
          state_d   = RUN;
        end
      end
      RUN: begin
        // Abort outranks completion, so a dropped request never sees done.
        if (!req[owner_q]) begin
          state_d = IDLE;
        end else if (cntQ == target_q) begin
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      rrPtr_q   <= '0;
      target_q  <= '0;
      cntMode_q <= 1'b0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rrPtr_q   <= rrPtr_d;
      target_q  <= target_d;
      cntMode_q <= cntMode_d;
      done_q    <= done_d;
    end
  end

  updown_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(loadVal),
    .step    (step),
    .mode    (cntMode_q),
    .q       (cntQ)
  );

  always_comb begin
    gnt = '0;
    if (state_q == RUN) begin
      gnt[owner_q] = 1'b1;
    end
  end

  assign done     = done_q;
  assign busy     = (state_q == RUN);
  assign count    = cntQ;
  assign cnt_mode = cntMode_q;

endmodule
